// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC output stage: datapath width, tag field layout,
// octant enumeration and the saturating negate used by the octant mapper.
package cordic_pkg;

    localparam int W         = 16;
    localparam int TAG_W     = 11;
    localparam int VALID_BIT = 10;
    localparam int OCT_MSB   = 9;
    localparam int OCT_LSB   = 7;
    localparam int IDX_MSB   = 6;
    localparam int LVL_W     = 5;

    typedef enum logic [2:0] {
        OCT_0 = 3'd0,
        OCT_1 = 3'd1,
        OCT_2 = 3'd2,
        OCT_3 = 3'd3,
        OCT_4 = 3'd4,
        OCT_5 = 3'd5,
        OCT_6 = 3'd6,
        OCT_7 = 3'd7
    } octant_e;

    // Operates on a sign-extended 32-bit value so any width up to 32 can share it;
    // the most negative w-bit value maps to the most positive one instead of wrapping.
    function automatic logic [31:0] sat_neg(input logic [31:0] v, input int w);
        logic [31:0] min_v;
        min_v = 32'hFFFF_FFFF << (w - 1);
        if (v == min_v) begin
            return ~min_v;
        end
        return -v;
    endfunction

endpackage

// File: rtl/cordic_out_fifo.sv
// First-word fall-through register FIFO with exact occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module cordic_out_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 39
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DW-1:0]                  data_in,
    output logic [DW-1:0]                  data_out,
    output logic                           full,
    output logic                           empty,
    output logic [cordic_pkg::LVL_W-1:0]   level
);
    import cordic_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [DEPTH-1:0] w_we;

    assign empty   = (r_level == '0);
    assign full    = (r_level == LVL_W'(DEPTH));
    assign w_rd_en = pop && !empty;
    assign w_wr_en = push && (!full || w_rd_en);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_wr_en && (r_wr_ptr == AW'(gi));
        end
    endgenerate

    // Entries are cleared on reset so the head never reads as X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign data_out = r_mem[r_rd_ptr];
    assign level    = r_level;

endmodule

// File: rtl/cordic_out_stage.sv
// CORDIC output stage: maps the final (X,Y) into the true octant with saturating
// negation, registers it, and buffers results in a non-stalling output FIFO.
module cordic_out_stage #(
    parameter int DEPTH = 4,
    parameter int W     = cordic_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [10:0]  index_cor_in,
    input  logic         out_ready,
    input  logic         clr_ovf,
    output logic [W-1:0] cos_out,
    output logic [W-1:0] sin_out,
    output logic [6:0]   idx_out,
    output logic         out_valid,
    output logic [4:0]   level,
    output logic         ovf
);
    import cordic_pkg::*;

    localparam int DW = 2 * W + IDX_MSB + 1;

    logic [W-1:0]      w_neg_x;
    logic [W-1:0]      w_neg_y;
    logic [W-1:0]      w_c;
    logic [W-1:0]      w_s;
    logic              r_s1_valid;
    logic [W-1:0]      r_s1_c;
    logic [W-1:0]      r_s1_s;
    logic [IDX_MSB:0]  r_s1_idx;
    logic [DW-1:0]     w_fifo_out;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;
    logic              r_ovf;

    assign w_neg_x = W'(sat_neg(32'(signed'(x_in)), W));
    assign w_neg_y = W'(sat_neg(32'(signed'(y_in)), W));

    always_comb begin
        w_c = x_in;
        w_s = y_in;
        case (octant_e'(index_cor_in[OCT_MSB:OCT_LSB]))
            OCT_0: begin w_c = x_in;    w_s = y_in;    end
            OCT_1: begin w_c = y_in;    w_s = x_in;    end
            OCT_2: begin w_c = w_neg_y; w_s = x_in;    end
            OCT_3: begin w_c = w_neg_x; w_s = y_in;    end
            OCT_4: begin w_c = w_neg_x; w_s = w_neg_y; end
            OCT_5: begin w_c = w_neg_y; w_s = w_neg_x; end
            OCT_6: begin w_c = y_in;    w_s = w_neg_x; end
            OCT_7: begin w_c = x_in;    w_s = w_neg_y; end
            default: begin w_c = x_in;  w_s = y_in;    end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_c     <= '0;
            r_s1_s     <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= index_cor_in[VALID_BIT];
            if (index_cor_in[VALID_BIT]) begin
                r_s1_c   <= w_c;
                r_s1_s   <= w_s;
                r_s1_idx <= index_cor_in[IDX_MSB:0];
            end
        end
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = r_s1_valid && w_full && !w_pop;

    cordic_out_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (r_s1_valid),
        .pop      (w_pop),
        .data_in  ({r_s1_idx, r_s1_s, r_s1_c}),
        .data_out (w_fifo_out),
        .full     (w_full),
        .empty    (w_empty),
        .level    (level)
    );

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign cos_out = w_fifo_out[W-1:0];
    assign sin_out = w_fifo_out[2*W-1:W];
    assign idx_out = w_fifo_out[DW-1:2*W];
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_cordic_out_stage.sv
// Self-checking bench for cordic_out_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_cordic_out_stage;

    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [10:0]  index_cor_in;
    logic         out_ready;
    logic         clr_ovf;
    logic [W-1:0] cos_out;
    logic [W-1:0] sin_out;
    logic [6:0]   idx_out;
    logic         out_valid;
    logic [4:0]   level;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_out_stage #(.DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .x_in         (x_in),
        .y_in         (y_in),
        .index_cor_in (index_cor_in),
        .out_ready    (out_ready),
        .clr_ovf      (clr_ovf),
        .cos_out      (cos_out),
        .sin_out      (sin_out),
        .idx_out      (idx_out),
        .out_valid    (out_valid),
        .level        (level),
        .ovf          (ovf)
    );

    typedef struct packed {
        logic [15:0] c;
        logic [15:0] s;
        logic [6:0]  idx;
    } ent_t;

    ent_t m_q[$];
    logic m_s1_v = 1'b0;
    ent_t m_s1;
    logic m_ovf = 1'b0;

    function automatic int sneg(int v);
        return (v == -32768) ? 32767 : -v;
    endfunction

    function automatic ent_t ref_map(logic [15:0] x, logic [15:0] y, logic [2:0] oct, logic [6:0] idx);
        ent_t e;
        int xs, ys, c, s;
        xs = $signed(x);
        ys = $signed(y);
        case (oct)
            3'd0: begin c = xs;       s = ys;       end
            3'd1: begin c = ys;       s = xs;       end
            3'd2: begin c = sneg(ys); s = xs;       end
            3'd3: begin c = sneg(xs); s = ys;       end
            3'd4: begin c = sneg(xs); s = sneg(ys); end
            3'd5: begin c = sneg(ys); s = sneg(xs); end
            3'd6: begin c = ys;       s = sneg(xs); end
            default: begin c = xs;    s = sneg(ys); end
        endcase
        e.c   = c[15:0];
        e.s   = s[15:0];
        e.idx = idx;
        return e;
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising edge, settle.
    task automatic step(logic [15:0] x, logic [15:0] y, logic [10:0] tag, logic rdy, logic clr);
        bit drop;
        @(negedge clk);
        x_in = x; y_in = y; index_cor_in = tag; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        drop = 1'b0;
        if (m_s1_v) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_s1);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_s1_v = tag[10];
        m_s1   = ref_map(x, y, tag[9:7], tag[6:0]);
        #1;
        $display("txn t=%0t tag=%h rdy=%0d clr=%0d -> valid=%0d level=%0d ovf=%0d cos=%h sin=%h idx=%0d",
                 $time, tag, rdy, clr, out_valid, level, ovf, cos_out, sin_out, idx_out);
    endtask

    task automatic idle(logic rdy, logic clr);
        step(16'($urandom), 16'($urandom), {1'b0, 10'($urandom)}, rdy, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        m_q.delete();
        m_s1_v = 1'b0;
        m_ovf  = 1'b0;
        #1;
        checks++;
        if ({out_valid, level, ovf} !== 7'd0)
            $display("FAIL reset_ctrl: valid=%0d level=%0d ovf=%0d, required 0/0/0", out_valid, level, ovf);
        else checks += 0;
        if ({out_valid, level, ovf} !== 7'd0) failures++;
        checks++;
        if ({cos_out, sin_out, idx_out} !== 39'd0) begin
            $display("FAIL reset_data: cos=%h sin=%h idx=%h, required zero", cos_out, sin_out, idx_out);
            failures++;
        end
        index_cor_in = 11'd0;
        out_ready    = 1'b0;
        clr_ovf      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, level, ovf, cos_out, sin_out, idx_out} !== 46'd0) begin
            $display("FAIL test_reset: valid=%0d level=%0d ovf=%0d cos=%h sin=%h idx=%h, required all zero",
                     out_valid, level, ovf, cos_out, sin_out, idx_out);
            failures++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        step(16'h2000, 16'h1000, {1'b1, 3'd2, 7'd5}, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_latency1: out_valid=%0d, required 0", out_valid); failures++;
        end
        idle(1'b1, 1'b0);
        checks++;
        if ({out_valid, cos_out, sin_out, idx_out, level} !== {1'b1, 16'hF000, 16'h2000, 7'd5, 5'd1}) begin
            $display("FAIL basic_result: valid=%0d cos=%h sin=%h idx=%0d level=%0d, required 1 f000 2000 5 1",
                     out_valid, cos_out, sin_out, idx_out, level);
            failures++;
        end
        idle(1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_pop: out_valid=%0d, required 0", out_valid); failures++;
        end
    endtask

    task automatic test_saturate();
        step(16'h8000, 16'h1234, {1'b1, 3'd3, 7'd9}, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checks++;
        if ({cos_out, sin_out} !== {16'h7FFF, 16'h1234}) begin
            $display("FAIL sat_x_oct3: cos=%h sin=%h, required 7fff 1234", cos_out, sin_out); failures++;
        end
        step(16'h0100, 16'h8000, {1'b1, 3'd4, 7'd10}, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        checks++;
        if ({cos_out, sin_out, idx_out} !== {16'hFF00, 16'h7FFF, 7'd10}) begin
            $display("FAIL sat_y_oct4: cos=%h sin=%h idx=%0d, required ff00 7fff 10", cos_out, sin_out, idx_out);
            failures++;
        end
        idle(1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        idle(1'b0, 1'b1);
        for (int k = 1; k <= 6; k++)
            step(16'($urandom), 16'($urandom), {1'b1, 3'($urandom), 7'(k)}, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checks++;
        if ({level, ovf} !== {5'd4, 1'b1}) begin
            $display("FAIL ovf_fill: level=%0d ovf=%0d, required 4 1", level, ovf); failures++;
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({out_valid, idx_out, cos_out, sin_out} !== {1'b1, 7'(k), m_q[0].c, m_q[0].s}) begin
                $display("FAIL ovf_order: valid=%0d idx=%0d cos=%h sin=%h, required 1 %0d %h %h",
                         out_valid, idx_out, cos_out, sin_out, k, m_q[0].c, m_q[0].s);
                failures++;
            end
            idle(1'b1, 1'b0);
        end
        checks++;
        if ({out_valid, level} !== 6'd0) begin
            $display("FAIL ovf_drained: valid=%0d level=%0d, required 0 0", out_valid, level); failures++;
        end
    endtask

    task automatic test_full_stream();
        idle(1'b0, 1'b1);
        for (int k = 0; k < 5; k++)
            step(16'($urandom), 16'($urandom), {1'b1, 3'($urandom), 7'(10 + k)}, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(16'($urandom), 16'($urandom), {1'b1, 3'($urandom), 7'(20 + k)}, 1'b1, 1'b0);
            checks++;
            if ({level, ovf, idx_out, cos_out, sin_out} !== {5'd4, 1'b0, m_q[0].idx, m_q[0].c, m_q[0].s}) begin
                $display("FAIL full_stream: level=%0d ovf=%0d idx=%0d cos=%h sin=%h, required 4 0 %0d %h %h",
                         level, ovf, idx_out, cos_out, sin_out, m_q[0].idx, m_q[0].c, m_q[0].s);
                failures++;
            end
        end
        repeat (6) idle(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++)
            step(16'($urandom), 16'($urandom), {1'b1, 3'($urandom), 7'(40 + k)}, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd3) begin
            $display("FAIL mid_level: level=%0d, required 3", level); failures++;
        end
        do_reset();
        step(16'h0123, 16'h0456, {1'b1, 3'd0, 7'd99}, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL post_reset_lat1: out_valid=%0d, required 0", out_valid); failures++;
        end
        idle(1'b0, 1'b0);
        checks++;
        if ({out_valid, level, idx_out, cos_out, sin_out} !== {1'b1, 5'd1, 7'd99, 16'h0123, 16'h0456}) begin
            $display("FAIL post_reset_lat2: valid=%0d level=%0d idx=%0d cos=%h sin=%h, required 1 1 99 0123 0456",
                     out_valid, level, idx_out, cos_out, sin_out);
            failures++;
        end
        idle(1'b1, 1'b0);
    endtask

    task automatic test_ovf_clr();
        for (int k = 0; k < 5; k++)
            step(16'($urandom), 16'($urandom), {1'b1, 3'($urandom), 7'(60 + k)}, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        checks++;
        if ({ovf, level} !== {1'b1, 5'd4}) begin
            $display("FAIL ovf_set_wins: ovf=%0d level=%0d, required 1 4", ovf, level); failures++;
        end
        idle(1'b0, 1'b1);
        checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_clear: ovf=%0d, required 0", ovf); failures++;
        end
        repeat (5) idle(1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            step(16'($urandom), 16'($urandom), 11'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) == 0));
            checks++;
            if ({out_valid, level, ovf} !== {m_q.size() > 0, 5'(m_q.size()), m_ovf}) begin
                $display("FAIL rand_ctrl: valid=%0d level=%0d ovf=%0d, required %0d %0d %0d",
                         out_valid, level, ovf, m_q.size() > 0, m_q.size(), m_ovf);
                failures++;
            end
            if (m_q.size() > 0) begin
                checks++;
                if ({cos_out, sin_out, idx_out} !== {m_q[0].c, m_q[0].s, m_q[0].idx}) begin
                    $display("FAIL rand_data: cos=%h sin=%h idx=%0d, required %h %h %0d",
                             cos_out, sin_out, idx_out, m_q[0].c, m_q[0].s, m_q[0].idx);
                    failures++;
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        x_in         = '0;
        y_in         = '0;
        index_cor_in = '0;
        out_ready    = 1'b0;
        clr_ovf      = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_full_stream();
        test_reset_mid();
        test_ovf_clr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
